ibex_data_responder: RTL

Memory-side responder for the Ibex core data port (req/gnt/rvalid/err protocol), serving a word-addressed SRAM array. It adds programmable grant wait states, a response latency and an outstanding-request limit, so LSU back-pressure and timing-dependent leakage can be exercised in latency experiments. It drops in where the data RAM connects to the core's `data_*` signals.

---
 rtl/ibex_data_resp_pkg.sv | 29 ++
 rtl/ibex_data_resp_delay.sv | 42 ++++
 rtl/ibex_data_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ibex_data_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_data_resp_pkg
//  Description : Shared types and parameter limits for the Ibex data-port
//                responder (response record, legal ranges, counter widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package ibex_data_resp_pkg;

    // One response travelling down the delay line
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    // Legal ranges of the timing parameters; out-of-range values are clamped
    localparam int unsigned GNT_WAIT_MAX        = 15;
    localparam int unsigned RESP_WAIT_MIN       = 1;
    localparam int unsigned RESP_WAIT_MAX       = 8;
    localparam int unsigned MAX_OUTSTANDING_MIN = 1;
    localparam int unsigned MAX_OUTSTANDING_MAX = 8;

    // Counter widths sized for the range limits above
    localparam int unsigned WAIT_CNT_W = 4;
    localparam int unsigned OUT_CNT_W  = 4;

endpackage
`default_nettype wire

// File: rtl/ibex_data_resp_delay.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_data_resp_delay
//  Description : RESP_WAIT-stage shift register of responses. Stage 0 loads
//                at the accept edge, the last stage drives the bus outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibex_data_resp_delay
    import ibex_data_resp_pkg::*;
#(
    parameter int unsigned RESP_WAIT = 1
) (
    input  logic  clk_sys,
    input  logic  rst_sys_n,
    input  resp_t resp_i,
    output resp_t resp_o
);

    resp_t stage_q [RESP_WAIT];
    resp_t stage_d [RESP_WAIT];

    // Next state: new entry into stage 0, every other stage takes its predecessor
    always_comb begin
        stage_d[0] = resp_i;
        for (int unsigned i = 1; i < RESP_WAIT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipeline registers; reset discards every pending response
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign resp_o = stage_q[RESP_WAIT-1];

endmodule
`default_nettype wire

// File: rtl/ibex_data_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ibex_data_responder
//  Description : Memory-side responder for the Ibex data port. Serves a
//                word-addressed SRAM with programmable grant wait states,
//                response latency and an outstanding-request limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibex_data_responder
    import ibex_data_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned GNT_WAIT        = 0,
    parameter int unsigned RESP_WAIT       = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned GNT_WAIT_C = (GNT_WAIT > GNT_WAIT_MAX) ? GNT_WAIT_MAX : GNT_WAIT;
    localparam int unsigned RESP_WAIT_C =
        (RESP_WAIT < RESP_WAIT_MIN) ? RESP_WAIT_MIN :
        (RESP_WAIT > RESP_WAIT_MAX) ? RESP_WAIT_MAX : RESP_WAIT;
    localparam int unsigned MAX_OUT_C =
        (MAX_OUTSTANDING < MAX_OUTSTANDING_MIN) ? MAX_OUTSTANDING_MIN :
        (MAX_OUTSTANDING > MAX_OUTSTANDING_MAX) ? MAX_OUTSTANDING_MAX : MAX_OUTSTANDING;
    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    // End of the mapped window, held in 33 bits so a window touching the top
    // of the address space does not wrap to a small value
    localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) * 33'd4);

    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [OUT_CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic                  accept;
    logic                  addr_err;
    logic [31:0]           addr_off;
    logic [IDX_W-1:0]      word_idx;
    resp_t                 resp_in;
    resp_t                 resp_out;
    logic [31:0]           mem_q [MEM_WORDS];

    // A response leaving the pipe frees a slot in the same cycle
    assign gnt_o  = req_i
                 && (wait_cnt_q == WAIT_CNT_W'(GNT_WAIT_C))
                 && ((out_cnt_q < OUT_CNT_W'(MAX_OUT_C)) || rvalid_o);
    assign accept = req_i && gnt_o;

    // Address decode: alignment and window bounds, word index within the array
    always_comb begin
        addr_off = addr_i - BASE_ADDR;
        word_idx = IDX_W'(addr_off >> 2);
        addr_err = (addr_i[1:0] != 2'b00)
                || (addr_i < BASE_ADDR)
                || ({1'b0, addr_i} >= ADDR_END);
    end

    // Response record captured at acceptance; reads sample the whole word
    always_comb begin
        resp_in = '0;
        if (accept) begin
            resp_in.valid = 1'b1;
            resp_in.err   = addr_err;
            if (!addr_err && !we_i) begin
                resp_in.rdata = mem_q[word_idx];
            end
        end
    end

    // Byte-masked array write at the accept edge; contents are never reset
    always_ff @(posedge clk_sys) begin
        if (accept && we_i && !addr_err) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_q[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Grant wait counter and outstanding-request counter next state
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req_i || accept) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_CNT_W'(GNT_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        out_cnt_d = out_cnt_q;
        if (accept && !rvalid_o) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!accept && rvalid_o) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            wait_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    ibex_data_resp_delay #(
        .RESP_WAIT (RESP_WAIT_C)
    ) u_delay (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .resp_i    (resp_in),
        .resp_o    (resp_out)
    );

    assign rvalid_o = resp_out.valid;
    assign err_o    = resp_out.valid & resp_out.err;
    assign rdata_o  = resp_out.valid ? resp_out.rdata : 32'h0;

endmodule
`default_nettype wire
